// File: rtl/axis_rx_pkg.sv
// Shared constants and types for the AXI-Stream receive frame FIFO.
package axis_rx_pkg;

  localparam int DEF_BITS  = 8;
  localparam int DEF_DEPTH = 16;
  localparam int DEF_LEN_W = 16;

  // Frame tracking state: between frames, or somewhere inside one.
  typedef enum logic {
    IDLE     = 1'b0,
    IN_FRAME = 1'b1
  } frame_state_t;

  // Layout of one stored beat at the default data width.
  typedef struct packed {
    logic                last;
    logic [DEF_BITS-1:0] data;
  } rx_entry_t;

endpackage

// File: rtl/axis_rx_sync_fifo.sv
// First-word-fall-through synchronous FIFO holding {last, data} entries.
// Ready is registered from the next-state occupancy, so it never depends
// combinationally on the push or pop requests of the current cycle.
module axis_rx_sync_fifo #(
  parameter int BITS  = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     wr_en_i,
  input  logic [BITS:0]            wr_data_i,
  output logic                     wr_ready_o,
  input  logic                     rd_en_i,
  output logic                     rd_valid_o,
  output logic [BITS:0]            rd_data_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [BITS:0]   mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [LW-1:0]   level_q, level_d;
  logic            ready_q;
  logic            push, pop;

  assign push = wr_en_i && ready_q;
  assign pop  = rd_en_i && (level_q != '0);

  // Occupancy next state: simultaneous push and pop leaves level unchanged.
  always_comb begin
    level_d = level_q;
    if (push && !pop) begin
      level_d = level_q + LW'(1);
    end else if (pop && !push) begin
      level_d = level_q - LW'(1);
    end
  end

  // Pointer, occupancy and ready registers; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      ready_q  <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      level_q <= level_d;
      ready_q <= (level_d != LW'(DEPTH));
    end
  end

  // Storage write; contents are not cleared by reset.
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q] <= wr_data_i;
  end

  assign wr_ready_o = ready_q;
  assign rd_valid_o = (level_q != '0);
  assign rd_data_o  = mem_q[rd_ptr_q];
  assign level_o    = level_q;

endmodule

// File: rtl/axis_rx_frame_fifo.sv
// AXI-Stream receive buffer with frame boundary tracking.
// Accepted beats go into an FWFT FIFO; a small FSM counts beats per frame
// and reports each completed frame the cycle after its tlast beat lands.
module axis_rx_frame_fifo
  import axis_rx_pkg::*;
#(
  parameter int BITS  = DEF_BITS,
  parameter int DEPTH = DEF_DEPTH,
  parameter int LEN_W = DEF_LEN_W
) (
  input  logic                   aclk,
  input  logic                   areset,
  input  logic [BITS-1:0]        s_tdata,
  input  logic                   s_tvalid,
  input  logic                   s_tlast,
  output logic                   s_tready,
  input  logic                   rd_en,
  output logic                   rd_valid,
  output logic [BITS-1:0]        rd_data,
  output logic                   rd_last,
  output logic [$clog2(DEPTH):0] level,
  output logic                   frame_done,
  output logic [LEN_W-1:0]       frame_len,
  output logic [15:0]            frame_count
);

  logic             accept;
  logic [BITS:0]    wr_entry, rd_entry;
  frame_state_t     state_q, state_d;
  logic [LEN_W-1:0] beat_cnt_q, beat_cnt_d, beat_inc;
  logic [LEN_W-1:0] frame_len_q, frame_len_d;
  logic [15:0]      frame_count_q, frame_count_d;
  logic             done_q, done_d;

  // Beat counter increment that sticks at the all-ones value.
  function automatic logic [LEN_W-1:0] sat_inc(input logic [LEN_W-1:0] v);
    return (&v) ? v : v + LEN_W'(1);
  endfunction

  assign accept   = s_tvalid && s_tready;
  assign wr_entry = {s_tlast, s_tdata};

  axis_rx_sync_fifo #(
    .BITS  (BITS),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i      (aclk),
    .rst_i      (areset),
    .wr_en_i    (s_tvalid),
    .wr_data_i  (wr_entry),
    .wr_ready_o (s_tready),
    .rd_en_i    (rd_en),
    .rd_valid_o (rd_valid),
    .rd_data_o  (rd_entry),
    .level_o    (level)
  );

  assign rd_last = rd_entry[BITS];
  assign rd_data = rd_entry[BITS-1:0];

  // Frame FSM and counters: a tlast accept closes the frame and latches its length.
  always_comb begin
    state_d       = state_q;
    beat_cnt_d    = beat_cnt_q;
    frame_len_d   = frame_len_q;
    frame_count_d = frame_count_q;
    done_d        = 1'b0;
    beat_inc      = sat_inc(beat_cnt_q);
    if (accept) begin
      if (s_tlast) begin
        state_d       = IDLE;
        beat_cnt_d    = '0;
        frame_len_d   = beat_inc;
        frame_count_d = frame_count_q + 16'd1;
        done_d        = 1'b1;
      end else begin
        state_d    = IN_FRAME;
        beat_cnt_d = beat_inc;
      end
    end
  end

  // Frame state registers; reset drops any partially received frame.
  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q       <= IDLE;
      beat_cnt_q    <= '0;
      frame_len_q   <= '0;
      frame_count_q <= '0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      beat_cnt_q    <= beat_cnt_d;
      frame_len_q   <= frame_len_d;
      frame_count_q <= frame_count_d;
      done_q        <= done_d;
    end
  end

  assign frame_done  = done_q;
  assign frame_len   = frame_len_q;
  assign frame_count = frame_count_q;

endmodule

// File: tb/tb_axis_rx_frame_fifo.sv
// Directed bench for axis_rx_frame_fifo: a vector table for the basic
// frame/pop flow plus hand-written sequences for fill, streaming,
// mid-frame reset and length saturation.
module tb_axis_rx_frame_fifo;

  logic       aclk = 1'b0;
  logic       areset;
  logic [7:0] s_tdata;
  logic       s_tvalid, s_tlast, s_tready;
  logic       rd_en, rd_valid, rd_last;
  logic [7:0] rd_data;
  logic [4:0] level;
  logic       frame_done;
  logic [15:0] frame_len, frame_count;

  // Second instance with a tiny length counter to exercise saturation.
  logic [7:0] d2;
  logic       v2, l2, rdy2, rden2, rv2, rl2, done2;
  logic [7:0] rdat2;
  logic [2:0] lvl2;
  logic [1:0] len2;
  logic [15:0] cnt2;

  int total = 0;
  int bad   = 0;

  always #5 aclk = ~aclk;

  axis_rx_frame_fifo #(.BITS(8), .DEPTH(16), .LEN_W(16)) dut (
    .aclk(aclk), .areset(areset), .s_tdata(s_tdata), .s_tvalid(s_tvalid),
    .s_tlast(s_tlast), .s_tready(s_tready), .rd_en(rd_en), .rd_valid(rd_valid),
    .rd_data(rd_data), .rd_last(rd_last), .level(level), .frame_done(frame_done),
    .frame_len(frame_len), .frame_count(frame_count)
  );

  axis_rx_frame_fifo #(.BITS(8), .DEPTH(4), .LEN_W(2)) dut2 (
    .aclk(aclk), .areset(areset), .s_tdata(d2), .s_tvalid(v2),
    .s_tlast(l2), .s_tready(rdy2), .rd_en(rden2), .rd_valid(rv2),
    .rd_data(rdat2), .rd_last(rl2), .level(lvl2), .frame_done(done2),
    .frame_len(len2), .frame_count(cnt2)
  );

  typedef struct {
    logic       v;
    logic [7:0] d;
    logic       l;
    logic       rd;
    int         lvl;
    int         rdy;
    int         rv;
    logic       chkd;
    int         rdat;
    int         rlast;
    int         done;
    int         flen;
    int         fcnt;
  } vec_t;

  vec_t tbl[18];

  function automatic vec_t mk(input int v, input int d, input int l, input int rd,
                              input int lvl, input int rdy, input int rv, input int chkd,
                              input int rdat, input int rlast, input int done,
                              input int flen, input int fcnt);
    vec_t t;
    t.v = v[0]; t.d = d[7:0]; t.l = l[0]; t.rd = rd[0];
    t.lvl = lvl; t.rdy = rdy; t.rv = rv; t.chkd = chkd[0];
    t.rdat = rdat; t.rlast = rlast; t.done = done; t.flen = flen; t.fcnt = fcnt;
    return t;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic idle_inputs();
    s_tvalid = 1'b0; s_tdata = 8'h00; s_tlast = 1'b0; rd_en = 1'b0;
    v2 = 1'b0; d2 = 8'h00; l2 = 1'b0; rden2 = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    areset = 1'b1;
    tick();
    areset = 1'b0;
    tick();
  endtask

  initial begin
    // Columns: v d l rd | level ready rv chkd rdata rlast done flen fcnt
    tbl[0]  = mk(1, 'h11, 0, 0,  1, 1, 1, 1, 'h11, 0, 0, 0, 0);
    tbl[1]  = mk(1, 'h22, 0, 0,  2, 1, 1, 1, 'h11, 0, 0, 0, 0);
    tbl[2]  = mk(1, 'h33, 1, 0,  3, 1, 1, 1, 'h11, 0, 1, 3, 1);
    tbl[3]  = mk(0, 'h00, 0, 0,  3, 1, 1, 1, 'h11, 0, 0, 3, 1);
    tbl[4]  = mk(0, 'h00, 0, 0,  3, 1, 1, 1, 'h11, 0, 0, 3, 1);
    tbl[5]  = mk(0, 'h00, 0, 1,  2, 1, 1, 1, 'h22, 0, 0, 3, 1);
    tbl[6]  = mk(0, 'h00, 0, 1,  1, 1, 1, 1, 'h33, 1, 0, 3, 1);
    tbl[7]  = mk(1, 'hA5, 1, 1,  1, 1, 1, 1, 'hA5, 1, 1, 1, 2);
    tbl[8]  = mk(0, 'h00, 0, 0,  1, 1, 1, 1, 'hA5, 1, 0, 1, 2);
    tbl[9]  = mk(0, 'h00, 0, 1,  0, 1, 0, 0, 0,    0, 0, 1, 2);
    tbl[10] = mk(0, 'h00, 0, 1,  0, 1, 0, 0, 0,    0, 0, 1, 2);
    tbl[11] = mk(0, 'h00, 0, 1,  0, 1, 0, 0, 0,    0, 0, 1, 2);
    tbl[12] = mk(0, 'h00, 0, 1,  0, 1, 0, 0, 0,    0, 0, 1, 2);
    tbl[13] = mk(0, 'h00, 0, 1,  0, 1, 0, 0, 0,    0, 0, 1, 2);
    tbl[14] = mk(1, 'h5A, 0, 0,  1, 1, 1, 1, 'h5A, 0, 0, 1, 2);
    tbl[15] = mk(1, 'h6B, 1, 1,  1, 1, 1, 1, 'h6B, 1, 1, 2, 3);
    tbl[16] = mk(0, 'h00, 0, 0,  1, 1, 1, 1, 'h6B, 1, 0, 2, 3);
    tbl[17] = mk(0, 'h00, 0, 1,  0, 1, 0, 0, 0,    0, 0, 2, 3);

    // Reset state
    idle_inputs();
    areset = 1'b1;
    tick();
    tick();
    check("rst.level", int'(level), 0);
    check("rst.ready", int'(s_tready), 0);
    check("rst.rd_valid", int'(rd_valid), 0);
    check("rst.done", int'(frame_done), 0);
    check("rst.len", int'(frame_len), 0);
    check("rst.count", int'(frame_count), 0);
    areset = 1'b0;
    tick();
    check("rst.ready_after", int'(s_tready), 1);

    // Table: 3-beat frame, pops, single-beat frame, empty pops, 2-beat frame
    for (int i = 0; i < 18; i++) begin
      s_tvalid = tbl[i].v; s_tdata = tbl[i].d; s_tlast = tbl[i].l; rd_en = tbl[i].rd;
      tick();
      check($sformatf("tbl%0d.level", i), int'(level), tbl[i].lvl);
      check($sformatf("tbl%0d.ready", i), int'(s_tready), tbl[i].rdy);
      check($sformatf("tbl%0d.rd_valid", i), int'(rd_valid), tbl[i].rv);
      if (tbl[i].chkd) begin
        check($sformatf("tbl%0d.rd_data", i), int'(rd_data), tbl[i].rdat);
        check($sformatf("tbl%0d.rd_last", i), int'(rd_last), tbl[i].rlast);
      end
      check($sformatf("tbl%0d.done", i), int'(frame_done), tbl[i].done);
      check($sformatf("tbl%0d.len", i), int'(frame_len), tbl[i].flen);
      check($sformatf("tbl%0d.count", i), int'(frame_count), tbl[i].fcnt);
    end
    idle_inputs();

    // Fill to full, then free one slot and accept beat 17
    do_reset();
    begin
      int sent = 0;
      for (int c = 0; c < 20; c++) begin
        logic rdy;
        s_tvalid = 1'b1; s_tdata = 8'(sent + 1); s_tlast = 1'b0;
        rdy = s_tready;
        tick();
        if (rdy) begin
          sent++;
          if (sent == 16) check("full.ready_fall", int'(s_tready), 0);
        end
      end
      check("full.sent", sent, 16);
      check("full.level", int'(level), 16);
      check("full.ready", int'(s_tready), 0);
      s_tdata = 8'd17; rd_en = 1'b1;
      tick();
      rd_en = 1'b0;
      check("full.pop_level", int'(level), 15);
      check("full.pop_ready", int'(s_tready), 1);
      tick();
      s_tvalid = 1'b0;
      check("full.b17_level", int'(level), 16);
      check("full.b17_ready", int'(s_tready), 0);
      for (int k = 0; k < 16; k++) begin
        check($sformatf("full.drain%0d", k), int'(rd_data), k + 2);
        rd_en = 1'b1;
        tick();
      end
      rd_en = 1'b0;
      check("full.drained", int'(level), 0);
    end

    // Half-full streaming with simultaneous push and pop
    do_reset();
    for (int i = 0; i < 8; i++) begin
      s_tvalid = 1'b1; s_tdata = 8'(8'h40 + i);
      tick();
    end
    check("half.level", int'(level), 8);
    for (int k = 0; k < 16; k++) begin
      s_tvalid = 1'b1; s_tdata = 8'(8'h48 + k); rd_en = 1'b1;
      check($sformatf("half.order%0d", k), int'(rd_data), 8'h40 + k);
      tick();
      check($sformatf("half.level%0d", k), int'(level), 8);
    end
    idle_inputs();

    // Reset in the middle of an open frame
    do_reset();
    for (int i = 0; i < 5; i++) begin
      s_tvalid = 1'b1; s_tdata = 8'(8'h80 + i); s_tlast = 1'b0;
      tick();
    end
    idle_inputs();
    areset = 1'b1;
    tick();
    check("mid.level", int'(level), 0);
    check("mid.rd_valid", int'(rd_valid), 0);
    check("mid.count", int'(frame_count), 0);
    check("mid.done", int'(frame_done), 0);
    areset = 1'b0;
    tick();
    check("mid.done_after", int'(frame_done), 0);
    check("mid.ready_after", int'(s_tready), 1);
    s_tvalid = 1'b1; s_tdata = 8'h01; s_tlast = 1'b0;
    tick();
    s_tdata = 8'h02; s_tlast = 1'b1;
    tick();
    idle_inputs();
    check("mid.new_done", int'(frame_done), 1);
    check("mid.new_len", int'(frame_len), 2);
    check("mid.new_count", int'(frame_count), 1);
    tick();
    check("mid.done_pulse", int'(frame_done), 0);
    check("mid.len_hold", int'(frame_len), 2);

    // Length saturation on a 2-bit counter
    do_reset();
    rden2 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      v2 = 1'b1; d2 = 8'(i); l2 = (i == 4);
      tick();
    end
    v2 = 1'b0; l2 = 1'b0;
    check("sat.done", int'(done2), 1);
    check("sat.len", int'(len2), 3);
    check("sat.count", int'(cnt2), 1);
    v2 = 1'b1; d2 = 8'h10; l2 = 1'b0;
    tick();
    d2 = 8'h11; l2 = 1'b1;
    tick();
    idle_inputs();
    check("sat.len2", int'(len2), 2);
    check("sat.count2", int'(cnt2), 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
